// File: rtl/game_pkg.sv
// Shared state codes for the game sequencer, display mux and the game/text generators.
package game_pkg;

  localparam logic [2:0] ST_MENU      = 3'b000;
  localparam logic [2:0] ST_COUNTDOWN = 3'b001;
  localparam logic [2:0] ST_PAUSE     = 3'b010;
  localparam logic [2:0] ST_OVER      = 3'b011;
  localparam logic [2:0] ST_PLAY      = 3'b100;

  typedef enum logic [2:0] {
    S_MENU      = ST_MENU,
    S_COUNTDOWN = ST_COUNTDOWN,
    S_PAUSE     = ST_PAUSE,
    S_OVER      = ST_OVER,
    S_PLAY      = ST_PLAY
  } state_e;

endpackage

// File: rtl/game_state_ctl_if.sv
// Signal bundle between the game sequencer (slave) and its environment (master).
interface game_state_ctl_if #(
  parameter int CNT_W = 10
);
  // No valid/ready handshake: inputs are levels sampled every clk, outputs are registered
  // levels (game_state, countdown_val) or single-cycle pulses (frame_tick, game_rst).
  logic             vblnk_in;
  logic             start_btn;
  logic             pause_btn;
  logic             game_over;
  logic [2:0]       game_state;
  logic             frame_tick;
  logic             game_rst;
  logic [CNT_W-1:0] countdown_val;

  modport master (
    output vblnk_in, start_btn, pause_btn, game_over,
    input  game_state, frame_tick, game_rst, countdown_val
  );

  modport slave (
    input  vblnk_in, start_btn, pause_btn, game_over,
    output game_state, frame_tick, game_rst, countdown_val
  );

endinterface

// File: rtl/game_state_ctl_rise_detect.sv
// Rising-edge detector with a registered one-cycle pulse; PREV_RST sets the assumed prior level.
module rise_detect #(
  parameter logic PREV_RST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= PREV_RST;
      pulse <= 1'b0;
    end else begin
      prev  <= d;
      pulse <= d & ~prev;
    end
  end

endmodule

// File: rtl/game_state_ctl.sv
// Game-level sequencer: latches button/game_over edges and applies state changes only on
// frame boundaries so the display mux never switches source mid-frame.
module game_state_ctl
  import game_pkg::*;
#(
  parameter int CNT_W            = 10,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int OVER_FRAMES      = 300
) (
  input  logic clk,
  input  logic rst,
  game_state_ctl_if.slave bus
);

  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] OV_LOAD = CNT_W'(OVER_FRAMES - 1);

  logic tick, start_e, pause_e, over_e;
  logic start_p, pause_p, over_p;
  logic eff_start, eff_pause, eff_over;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             game_rst_q;

  // vblnk prev resets high so a blank already active at reset release is not a frame edge.
  rise_detect #(.PREV_RST(1'b1)) u_vblnk (.clk(clk), .rst(rst), .d(bus.vblnk_in),  .pulse(tick));
  rise_detect #(.PREV_RST(1'b0)) u_start (.clk(clk), .rst(rst), .d(bus.start_btn), .pulse(start_e));
  rise_detect #(.PREV_RST(1'b0)) u_pause (.clk(clk), .rst(rst), .d(bus.pause_btn), .pulse(pause_e));
  rise_detect #(.PREV_RST(1'b0)) u_over  (.clk(clk), .rst(rst), .d(bus.game_over), .pulse(over_e));

  assign eff_start = start_p | start_e;
  assign eff_pause = pause_p | pause_e;
  assign eff_over  = over_p  | over_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_MENU;
      cnt_q      <= '0;
      game_rst_q <= 1'b0;
      start_p    <= 1'b0;
      pause_p    <= 1'b0;
      over_p     <= 1'b0;
    end else begin
      game_rst_q <= 1'b0;
      // Flags live for at most one frame: every tick clears them, consumed or not.
      if (tick) begin
        start_p <= 1'b0;
        pause_p <= 1'b0;
        over_p  <= 1'b0;
      end else begin
        if (start_e) start_p <= 1'b1;
        if (pause_e) pause_p <= 1'b1;
        if (over_e)  over_p  <= 1'b1;
      end

      case (state_q)
        S_MENU: begin
          if (tick && eff_start) begin
            state_q    <= S_COUNTDOWN;
            cnt_q      <= CD_LOAD;
            game_rst_q <= 1'b1;
          end
        end
        S_COUNTDOWN: begin
          if (tick) begin
            if (cnt_q == '0) state_q <= S_PLAY;
            else             cnt_q   <= cnt_q - 1'b1;
          end
        end
        S_PLAY: begin
          if (tick) begin
            if (eff_over) begin
              state_q <= S_OVER;
              cnt_q   <= OV_LOAD;
            end else if (eff_pause) begin
              state_q <= S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (tick && (eff_pause || eff_start)) state_q <= S_PLAY;
        end
        S_OVER: begin
          if (tick) begin
            if (cnt_q == '0) state_q <= S_MENU;
            else             cnt_q   <= cnt_q - 1'b1;
          end
        end
        default: begin
          // Corrupted code: recover immediately, without waiting for a frame boundary.
          state_q <= S_MENU;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.game_state    = state_q;
  assign bus.frame_tick    = tick;
  assign bus.game_rst      = game_rst_q;
  assign bus.countdown_val = (state_q == S_COUNTDOWN || state_q == S_OVER) ? cnt_q : '0;

endmodule
